// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MAR/MDR register pair with a request/ack memory access FSM,
//            wait-cycle timeout and sticky error status.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus,
    input  logic              mar_enable,
    input  logic              mdr_enable,
    input  logic              read_start,
    input  logic              write_start,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mdr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              err_flag
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Timeout fires at the edge where the count would reach TIMEOUT.
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_mar, w_mar_nxt;
    logic [DATA_W-1:0]   r_mdr, w_mdr_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic                r_flag, w_flag_nxt;
    logic                w_timeout;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mar   <= w_mar_nxt;
            r_mdr   <= w_mdr_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_flag  <= w_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mar_nxt   = r_mar;
        w_mdr_nxt   = r_mdr;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_flag_nxt  = r_flag;
        w_timeout   = (TIMEOUT > 0) && (r_cnt == c_LAST);

        case (r_state)
            S_IDLE: begin
                // Register loads share the start edge so the access sees fresh values.
                if (mar_enable) w_mar_nxt = bus[ADDR_W-1:0];
                if (mdr_enable) w_mdr_nxt = bus;
                if (read_start && write_start) begin
                    w_err_nxt  = 1'b1;
                    w_flag_nxt = 1'b1;
                end else if (read_start) begin
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = '0;
                    w_flag_nxt  = 1'b0;
                end else if (write_start) begin
                    w_state_nxt = S_WR;
                    w_cnt_nxt   = '0;
                    w_flag_nxt  = 1'b0;
                end
            end
            S_RD, S_WR: begin
                if (mem_ack) begin
                    if (r_state == S_RD) w_mdr_nxt = mem_rdata;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign mem_addr  = r_mar;
    assign mdr_data  = r_mdr;
    assign mem_wdata = r_mdr;
    assign mem_req   = (r_state != S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign mem_we    = (r_state == S_WR);
    assign done      = r_done;
    assign err       = r_err;
    assign err_flag  = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed vector table plus timeout / reset sequences for
//            mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus;
    logic        mar_enable, mdr_enable, read_start, write_start, mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] mdr_data, mem_wdata;
    logic [8:0]  mem_addr;
    logic        mem_req, mem_we, busy, done, err, err_flag;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus),
        .mar_enable (mar_enable),
        .mdr_enable (mdr_enable),
        .read_start (read_start),
        .write_start(write_start),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mdr_data   (mdr_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_flag   (err_flag)
    );

    // ctl = {mar_enable, mdr_enable, read_start, write_start, mem_ack}
    // eo  = {mem_req, mem_we, busy, done, err, err_flag}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] bus;
        logic [31:0] rdata;
        logic [5:0]  eo;
        logic [8:0]  ea;
        logic [31:0] em;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] b,
                                input logic [31:0] rd, input logic [5:0] eo,
                                input logic [8:0] ea, input logic [31:0] em);
        vec_t v;
        v.ctl = ctl; v.bus = b; v.rdata = rd; v.eo = eo; v.ea = ea; v.em = em;
        return v;
    endfunction

    task automatic drive(input logic [4:0] ctl, input logic [31:0] b, input logic [31:0] rd);
        {mar_enable, mdr_enable, read_start, write_start, mem_ack} = ctl;
        bus       = b;
        mem_rdata = rd;
    endtask

    task automatic check(input string name, input logic [5:0] eo,
                         input logic [8:0] ea, input logic [31:0] em);
        logic [5:0] ao;
        ao = {mem_req, mem_we, busy, done, err, err_flag};
        n_vec++;
        if (ao !== eo || mem_addr !== ea || mdr_data !== em || mem_wdata !== em) begin
            n_miss++;
            $display("FAIL %s: got flags=%b addr=%h mdr=%h wdata=%h, expected flags=%b addr=%h mdr=%h",
                     name, ao, mem_addr, mdr_data, mem_wdata, eo, ea, em);
        end
    endtask

    task automatic step(input string name, input logic [4:0] ctl, input logic [31:0] b,
                        input logic [31:0] rd, input logic [5:0] eo,
                        input logic [8:0] ea, input logic [31:0] em);
        drive(ctl, b, rd);
        @(posedge clk);
        #1;
        check(name, eo, ea, em);
    endtask

    initial begin
        vecs[0]  = mk(5'b10000, 32'h0000_01F5, 32'h0,         6'b000000, 9'h1F5, 32'h0);
        vecs[1]  = mk(5'b00100, 32'h0,         32'h0,         6'b101000, 9'h1F5, 32'h0);
        vecs[2]  = mk(5'b00000, 32'h0,         32'h0,         6'b101000, 9'h1F5, 32'h0);
        vecs[3]  = mk(5'b00000, 32'h0,         32'h0,         6'b101000, 9'h1F5, 32'h0);
        vecs[4]  = mk(5'b00001, 32'h0,         32'hDEADBEEF,  6'b000100, 9'h1F5, 32'hDEADBEEF);
        vecs[5]  = mk(5'b00000, 32'h0,         32'h0,         6'b000000, 9'h1F5, 32'hDEADBEEF);
        vecs[6]  = mk(5'b01010, 32'h12345678,  32'h0,         6'b111000, 9'h1F5, 32'h12345678);
        vecs[7]  = mk(5'b00001, 32'h0,         32'hFFFFFFFF,  6'b000100, 9'h1F5, 32'h12345678);
        vecs[8]  = mk(5'b00000, 32'h0,         32'h0,         6'b000000, 9'h1F5, 32'h12345678);
        vecs[9]  = mk(5'b00110, 32'h0,         32'h0,         6'b000011, 9'h1F5, 32'h12345678);
        vecs[10] = mk(5'b00000, 32'h0,         32'h0,         6'b000001, 9'h1F5, 32'h12345678);
        vecs[11] = mk(5'b00001, 32'h0,         32'hCAFEF00D,  6'b000001, 9'h1F5, 32'h12345678);
        vecs[12] = mk(5'b00100, 32'h0,         32'h0,         6'b101000, 9'h1F5, 32'h12345678);
        vecs[13] = mk(5'b11100, 32'h0000_00AA, 32'h0,         6'b101000, 9'h1F5, 32'h12345678);
        vecs[14] = mk(5'b01010, 32'h0000_0055, 32'h0,         6'b101000, 9'h1F5, 32'h12345678);
        vecs[15] = mk(5'b00001, 32'h0,         32'h0BADCAFE,  6'b000100, 9'h1F5, 32'h0BADCAFE);
        vecs[16] = mk(5'b10100, 32'hFFFF_FEAB, 32'h0,         6'b101000, 9'h0AB, 32'h0BADCAFE);
        vecs[17] = mk(5'b00001, 32'h0,         32'h11111111,  6'b000100, 9'h0AB, 32'h11111111);
        vecs[18] = mk(5'b00000, 32'h0,         32'h0,         6'b000000, 9'h0AB, 32'h11111111);

        clr = 1'b0;
        drive(5'b00000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 6'b000000, 9'h000, 32'h0);
        clr = 1'b1;

        for (int i = 0; i < 19; i++)
            step($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].bus, vecs[i].rdata,
                 vecs[i].eo, vecs[i].ea, vecs[i].em);

        // Read with mem_ack held low: err after 15 wait cycles, MDR kept.
        step("to_start", 5'b00100, 32'h0, 32'h0, 6'b101000, 9'h0AB, 32'h11111111);
        for (int k = 1; k <= 14; k++)
            step($sformatf("to_wait%0d", k), 5'b00000, 32'h0, 32'h99999999,
                 6'b101000, 9'h0AB, 32'h11111111);
        step("to_expire", 5'b00000, 32'h0, 32'h99999999, 6'b000011, 9'h0AB, 32'h11111111);
        step("to_after",  5'b00000, 32'h0, 32'h0,        6'b000001, 9'h0AB, 32'h11111111);

        // Write acked in the last allowed cycle counts as success; start clears err_flag.
        step("late_start", 5'b00010, 32'h0, 32'h0, 6'b111000, 9'h0AB, 32'h11111111);
        for (int k = 1; k <= 14; k++)
            step($sformatf("late_wait%0d", k), 5'b00000, 32'h0, 32'h0,
                 6'b111000, 9'h0AB, 32'h11111111);
        step("late_ack", 5'b00001, 32'h0, 32'h77777777, 6'b000100, 9'h0AB, 32'h11111111);
        step("late_idle", 5'b00000, 32'h0, 32'h0,       6'b000000, 9'h0AB, 32'h11111111);

        // Reset asserted in the 2nd RD cycle, between clock edges.
        step("rst_start", 5'b00100, 32'h0, 32'h0, 6'b101000, 9'h0AB, 32'h11111111);
        step("rst_rd1",   5'b00000, 32'h0, 32'h0, 6'b101000, 9'h0AB, 32'h11111111);
        #2;
        clr = 1'b0;
        #1;
        check("rst_async", 6'b000000, 9'h000, 32'h0);
        step("rst_held", 5'b00001, 32'h0, 32'h55555555, 6'b000000, 9'h000, 32'h0);
        clr = 1'b1;
        step("rst_rel1", 5'b00001, 32'h0, 32'h55555555, 6'b000000, 9'h000, 32'h0);
        step("rst_rel2", 5'b00000, 32'h0, 32'h0,        6'b000000, 9'h000, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
